// File: rtl/header_parser_pkg.sv
// Shared definitions for the header engine: Ethernet/IPv4 constants, word
// indices, parser states and field-strobe bundle.
package header_engine_defs;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP      = 8'd6;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;

    // Word indices within the frame, word0 being the sop word.
    localparam logic [4:0] W_ETYPE = 5'd3;
    localparam logic [4:0] W_PROT  = 5'd5;
    localparam logic [4:0] W_SA    = 5'd7;
    localparam logic [4:0] W_DA    = 5'd8;

    typedef enum logic [1:0] {S_IDLE, S_ETH, S_IP, S_SKIP} state_t;

    typedef struct packed {
        logic soh;
        logic prot;
        logic sa;
        logic da;
        logic sp_dp;
        logic eoh;
        logic hdr_err;
    } strobes_t;

    // Word3 carries the ethertype followed by the IPv4 version/IHL byte.
    function automatic logic is_ipv4_hdr(input logic [31:0] w);
        return (w[31:16] == ETHERTYPE_IPV4) && (w[15:12] == 4'd4) && (w[11:8] >= 4'd5);
    endfunction

    function automatic logic has_ports(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

endpackage

// File: rtl/header_parser_if.sv
// Word-stream tap into the header parser and the field strobes it produces.
interface header_parser_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [31:0] data;
    logic        soh;
    logic        prot;
    logic        sa;
    logic        da;
    logic        sp_dp;
    logic        eoh;
    logic        hdr_err;

    modport master (
        output in_data, in_valid, in_sop, in_eop,
        input  data, soh, prot, sa, da, sp_dp, eoh, hdr_err
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop,
        output data, soh, prot, sa, da, sp_dp, eoh, hdr_err
    );
endinterface

// File: rtl/header_parser_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/header_parser.sv
// Ethernet/IPv4 header walker: realigns IPv4 fields across the 2-byte
// Ethernet offset and emits one registered field strobe per cycle.
module header_parser
    import header_engine_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    header_parser_if.slave   bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] ipv4_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t      state, state_n;
    logic [4:0]  wcnt, wcnt_n;
    logic [3:0]  ihl, ihl_n;
    logic [7:0]  proto, proto_n;
    logic [15:0] prev_lo;
    logic        eoh_pend, eoh_pend_n;
    logic        err_pend, err_pend_n;
    strobes_t    strb, strb_n;
    logic [31:0] data_q, data_n;
    logic [31:0] realigned;
    logic        sp_dp_word;
    logic        pkt_inc;

    assign realigned = {prev_lo, bus.in_data[31:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            ihl      <= '0;
            proto    <= '0;
            prev_lo  <= '0;
            eoh_pend <= 1'b0;
            err_pend <= 1'b0;
            strb     <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            ihl      <= ihl_n;
            proto    <= proto_n;
            eoh_pend <= eoh_pend_n;
            err_pend <= err_pend_n;
            strb     <= strb_n;
            data_q   <= data_n;
            if (bus.in_valid) prev_lo <= bus.in_data[15:0];
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        ihl_n       = ihl;
        proto_n     = proto;
        data_n      = data_q;
        eoh_pend_n  = 1'b0;
        err_pend_n  = 1'b0;
        strb_n      = '0;
        strb_n.eoh     = eoh_pend;
        strb_n.hdr_err = err_pend;
        sp_dp_word  = 1'b0;
        pkt_inc     = 1'b0;

        if (bus.in_valid) begin
            wcnt_n = (wcnt == 5'd31) ? wcnt : wcnt + 5'd1;
            if (bus.in_sop) begin
                // A new frame always restarts the walk; an open IPv4 header is aborted.
                wcnt_n  = 5'd1;
                state_n = bus.in_eop ? S_IDLE : S_ETH;
                pkt_inc = bus.in_eop;
                if (state == S_IP) begin
                    strb_n.eoh     = 1'b1;
                    strb_n.hdr_err = 1'b1;
                end
            end else begin
                pkt_inc = bus.in_eop && (state != S_IDLE);
                case (state)
                    S_IDLE: wcnt_n = wcnt;
                    S_ETH: begin
                        if ((wcnt == W_ETYPE) && is_ipv4_hdr(bus.in_data)) begin
                            strb_n.soh = 1'b1;
                            data_n     = bus.in_data;
                            ihl_n      = bus.in_data[11:8];
                            state_n    = S_IP;
                            if (bus.in_eop) begin
                                eoh_pend_n = 1'b1;
                                err_pend_n = 1'b1;
                                state_n    = S_IDLE;
                            end
                        end else if (bus.in_eop) begin
                            state_n = S_IDLE;
                        end else if (wcnt == W_ETYPE) begin
                            state_n = S_SKIP;
                        end
                    end
                    S_IP: begin
                        sp_dp_word = (wcnt == ({1'b0, ihl} + 5'd4));
                        if (wcnt == W_PROT) begin
                            strb_n.prot = 1'b1;
                            data_n      = bus.in_data;
                            proto_n     = bus.in_data[7:0];
                        end else if (wcnt == W_SA) begin
                            strb_n.sa = 1'b1;
                            data_n    = realigned;
                        end else if (wcnt == W_DA) begin
                            strb_n.da = 1'b1;
                            data_n    = realigned;
                        end else if (sp_dp_word) begin
                            strb_n.sp_dp = 1'b1;
                            data_n       = has_ports(proto) ? realigned : 32'h0;
                            eoh_pend_n   = 1'b1;
                            state_n      = bus.in_eop ? S_IDLE : S_SKIP;
                        end
                        if (bus.in_eop && !sp_dp_word) begin
                            eoh_pend_n = 1'b1;
                            err_pend_n = 1'b1;
                            state_n    = S_IDLE;
                        end
                    end
                    S_SKIP: if (bus.in_eop) state_n = S_IDLE;
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    assign bus.data    = data_q;
    assign bus.soh     = strb.soh;
    assign bus.prot    = strb.prot;
    assign bus.sa      = strb.sa;
    assign bus.da      = strb.da;
    assign bus.sp_dp   = strb.sp_dp;
    assign bus.eoh     = strb.eoh;
    assign bus.hdr_err = strb.hdr_err;

    sat_counter #(.W(CNT_W)) u_pkt_cnt  (.clk(clk), .rst(rst), .inc(pkt_inc),        .count(pkt_cnt));
    sat_counter #(.W(CNT_W)) u_ipv4_cnt (.clk(clk), .rst(rst), .inc(strb_n.soh),     .count(ipv4_cnt));
    sat_counter #(.W(CNT_W)) u_err_cnt  (.clk(clk), .rst(rst), .inc(strb_n.hdr_err), .count(err_cnt));

endmodule

// File: doc/header_parser.md
Name: header_parser

Overview:
- Header-engine front end; sits directly upstream of the header consumer stage.
- Walks a 32-bit Ethernet/IPv4 word stream, realigns IPv4 fields across the 2-byte Ethernet offset, and emits single-cycle field strobes with the matching data word.
- Strobes: soh, prot, sa, da, sp_dp, eoh.
- Passive tap: no back-pressure; every in_valid word is consumed.

Parameters:
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_data  in  32  frame word; byte 4k in [31:24]
- in_valid  in  1  word qualifier
- in_sop  in  1  first word of frame; valid only with in_valid
- in_eop  in  1  last word of frame; valid only with in_valid
- data  out  32  field word accompanying a strobe
- soh, prot, sa, da, sp_dp, eoh  out  1 each  field strobes; one-cycle pulses
- hdr_err  out  1  truncated or aborted header; pulses with eoh
- pkt_cnt, ipv4_cnt, err_cnt  out  CNT_W each  frames seen, soh issued, hdr_err issued

Behaviour:
- Reset:
  - All outputs, counters, wcnt, ihl, proto, prev_lo and eoh_pend clear to 0.
  - State goes to S_IDLE.
  - Reset mid-frame drops the frame with no eoh.
- Output timing:
  - All outputs are registered.
  - A strobe appears exactly 1 cycle after the accepting in_valid edge.
  - At most one strobe is high per cycle.
  - data holds its value between strobes.
- Realignment:
  - prev_lo <= in_data[15:0] on every accepted word.
  - realigned word = {prev_lo, in_data[31:16]}.
- Word counter:
  - wcnt is 5 bits; word0 is the sop word.
  - Increments per accepted word and saturates at 31.
- S_IDLE:
  - Ignores words without in_sop.
  - On sop: wcnt <= 1, go S_ETH.
  - sop together with eop: count the frame, stay in S_IDLE.
- S_ETH (words 1–3), checks at word3:
  - in_data[31:16] == 16'h0800
  - in_data[15:12] == 4
  - in_data[11:8] >= 5
- S_ETH outcome:
  - Checks pass: pulse soh with data = word3, latch ihl, go S_IP.
  - Checks fail: go S_SKIP, no strobes.
- S_IP emissions (data in brackets):
  - word5: prot [raw word; protocol in [7:0]]; latch proto.
  - word7: sa [realigned].
  - word8: da [realigned].
  - word ihl+4: sp_dp [realigned if proto is 6 or 17, else 32'h0].
  - After sp_dp: set eoh_pend; go S_SKIP, or S_IDLE if that word is eop.
- eoh_pend: fires eoh on the following cycle, then clears.
  - Spacing guarantees eoh never coincides with another strobe.
- Truncation: eop in S_IP before word ihl+4:
  - Any strobe due for that word is still emitted.
  - Next cycle: eoh=1 and hdr_err=1; state goes to S_IDLE.
- Abort: sop while in S_IP (soh issued, no eoh yet):
  - Next cycle: eoh=1 and hdr_err=1.
  - The sop word is taken as word0 of the new frame; go S_ETH.
- sop in S_ETH or S_SKIP: restart at word0, no strobes.
- S_SKIP: discard words until eop, then go S_IDLE.
- Counters:
  - pkt_cnt +1 per eop.
  - ipv4_cnt +1 per soh.
  - err_cnt +1 per hdr_err.
  - All saturate at all-ones; no wrap.
- in_valid gaps: any length, in any state; no timeout.

Decomposition:
- Shared package header_engine_defs:
  - ETHERTYPE_IPV4=16'h0800, PROTO_TCP=8'd6, PROTO_UDP=8'd17
  - word indices W_ETYPE=3, W_PROT=5, W_SA=7, W_DA=8
  - state encodings S_IDLE, S_ETH, S_IP, S_SKIP
- Sub-module: sat_counter (CNT_W), instantiated three times.

Test Plan:
- TCP, IHL=5, 12-word frame; src 0x0A000001, dst 0xC0A80102, sport 0x1234, dport 0x0050, back-to-back words ->
  - soh after word3, prot after word5 (data[7:0]=0x06), sa 0x0A000001 after word7, da 0xC0A80102 after word8
  - sp_dp 0x12340050 after word9, eoh the next cycle; hdr_err=0
  - pkt_cnt=1, ipv4_cnt=1
- ARP frame (ethertype 0x0806), then UDP frame with 1-cycle gaps between words ->
  - ARP: no strobes.
  - UDP: prot data[7:0]=0x11, sp_dp realigned.
  - pkt_cnt=2, ipv4_cnt=1.
- IHL=6 TCP frame -> sp_dp after word10 (ports taken from bytes 38–41); eoh 1 cycle later.
- ICMP (proto 1) -> sp_dp data=32'h0; eoh with hdr_err=0.
- Frame ending at word7 -> sa emitted, then eoh+hdr_err next cycle, no da or sp_dp; err_cnt=1.
- Reset asserted after word6 -> all outputs 0 immediately, no eoh; the next frame parses normally.
